mem_arbiter: RTL and testbench

- Sits between two requesters and the SDRAM memory controller's single-command interface.
- Requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Grants one request at a time, round-robin between the ports, with periodic auto-refresh at top priority.
- Sequences the controller's issue/busy handshake and returns read data and a one-cycle ack per request.
- A watchdog flags a controller that never completes an operation.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin front end for the SDRAM controller
// with top-priority auto-refresh, busy handshake and a WAIT watchdog.
module mem_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int WAIT_TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [22:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_mask,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [22:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_mask,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        mc_read_a,
  output logic        mc_read_b,
  output logic        mc_write,
  output logic        mc_refresh,
  output logic [22:0] mc_addr,
  output logic [31:0] mc_din,
  output logic [3:0]  mc_mask,
  input  logic [31:0] mc_dout_a,
  input  logic [31:0] mc_dout_b,
  input  logic        mc_busy,
  input  logic        mc_initialized,
  output logic        timeout_err,
  output logic        refresh_missed
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int RW = $clog2(REFRESH_INTERVAL);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] wcnt;
  logic          pending;
  logic          last;
  logic          job_ref;
  logic          job_port;
  logic          job_rd;
  logic          wrap;
  logic          gnt_ref;
  logic          gnt0;
  logic          gnt1;
  logic          wait_end;

  assign wrap     = rcnt == RW'(REFRESH_INTERVAL - 1);
  assign wait_end = !mc_busy || (wcnt == TW'(WAIT_TIMEOUT));

  // grant decision: refresh first, then single requester, else the port not served last
  always_comb begin
    gnt_ref = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (state == IDLE && mc_initialized && !mc_busy) begin
      unique case (1'b1)
        pending: gnt_ref = 1'b1;
        !pending && p0_req && p1_req: begin
          gnt0 = last;
          gnt1 = !last;
        end
        !pending && p0_req && !p1_req: gnt0 = 1'b1;
        !pending && !p0_req && p1_req: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  // refresh interval timer; pending is consumed by a refresh grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rcnt           <= '0;
      pending        <= 1'b0;
      refresh_missed <= 1'b0;
    end else begin
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      if (wrap) begin
        pending <= 1'b1;
        if (pending) refresh_missed <= 1'b1;
      end else if (gnt_ref) begin
        pending <= 1'b0;
      end
    end
  end

  // job sequencer: IDLE -> ISSUE -> WAIT -> DONE, refresh returns from WAIT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last        <= 1'b0;
      job_ref     <= 1'b0;
      job_port    <= 1'b0;
      job_rd      <= 1'b0;
      wcnt        <= '0;
      mc_read_a   <= 1'b0;
      mc_read_b   <= 1'b0;
      mc_write    <= 1'b0;
      mc_refresh  <= 1'b0;
      mc_addr     <= '0;
      mc_din      <= '0;
      mc_mask     <= '0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_ref || gnt0 || gnt1) begin
            state      <= ISSUE;
            job_ref    <= gnt_ref;
            job_port   <= gnt1;
            job_rd     <= (gnt0 && !p0_we) || (gnt1 && !p1_we);
            mc_refresh <= gnt_ref;
            mc_read_a  <= gnt0 && !p0_we;
            mc_read_b  <= gnt1 && !p1_we;
            mc_write   <= (gnt0 && p0_we) || (gnt1 && p1_we);
            if (!gnt_ref) last <= gnt1;
            if (gnt0) begin
              mc_addr <= p0_addr;
              mc_din  <= p0_wdata;
              mc_mask <= p0_mask;
            end else if (gnt1) begin
              mc_addr <= p1_addr;
              mc_din  <= p1_wdata;
              mc_mask <= p1_mask;
            end else begin
              mc_addr <= '0;
              mc_din  <= '0;
              mc_mask <= '0;
            end
          end
        end
        ISSUE: begin
          mc_read_a  <= 1'b0;
          mc_read_b  <= 1'b0;
          mc_write   <= 1'b0;
          mc_refresh <= 1'b0;
          wcnt       <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (mc_busy && wcnt == TW'(WAIT_TIMEOUT)) timeout_err <= 1'b1;
          if (!mc_busy && job_rd && !job_port) p0_rdata <= mc_dout_a;
          if (!mc_busy && job_rd && job_port) p1_rdata <= mc_dout_b;
          if (wait_end) begin
            if (job_ref) begin
              state <= IDLE;
            end else begin
              state  <= DONE;
              p0_ack <= !job_port;
              p1_ack <= job_port;
            end
          end
        end
        DONE: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random two-port traffic against a queue scoreboard,
// with an SDRAM controller model, refresh, timeout and reset scenarios.
module tb_mem_arbiter;
  localparam int RI = 32;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0]       we = '0;
  logic [1:0]       ack;
  logic [1:0][22:0] addr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0][3:0]  mask = '0;
  logic [1:0][31:0] rdata;
  logic             mc_read_a, mc_read_b, mc_write, mc_refresh;
  logic [22:0]      mc_addr;
  logic [31:0]      mc_din;
  logic [3:0]       mc_mask;
  logic [31:0]      mc_dout_a = '0;
  logic [31:0]      mc_dout_b = '0;
  logic             mc_busy = 1'b0;
  logic             mc_initialized = 1'b0;
  logic             timeout_err, refresh_missed;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nref = 0;
  int prev_n = 0;
  int last_cmd_cyc = 0;
  int last_ack_cyc [2];
  int req_cyc [2];
  int cmdlog [$];
  int acklog [$];
  int ackcyc [$];
  logic [31:0] expq0 [$];
  logic [31:0] expq1 [$];
  logic [31:0] last_rd [2];
  logic [31:0] rmem [logic [22:0]];
  logic [31:0] cmem [logic [22:0]];
  int  busy_left = 0;
  bit  hang = 1'b0;
  bit  stuck = 1'b0;

  mem_arbiter #(.REFRESH_INTERVAL(RI), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]),
    .p0_wdata(wdata[0]), .p0_mask(mask[0]),
    .p0_ack(ack[0]), .p0_rdata(rdata[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]),
    .p1_wdata(wdata[1]), .p1_mask(mask[1]),
    .p1_ack(ack[1]), .p1_rdata(rdata[1]),
    .mc_read_a(mc_read_a), .mc_read_b(mc_read_b),
    .mc_write(mc_write), .mc_refresh(mc_refresh),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_mask(mc_mask),
    .mc_dout_a(mc_dout_a), .mc_dout_b(mc_dout_b),
    .mc_busy(mc_busy), .mc_initialized(mc_initialized),
    .timeout_err(timeout_err), .refresh_missed(refresh_missed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] initv(logic [22:0] a);
    if (a == 23'h100) return 32'hDEADBEEF;
    return {a[22:0], 9'h0} ^ 32'h5A5A_1234 ^ {9'h0, a};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] cread(logic [22:0] a);
    return cmem.exists(a) ? cmem[a] : initv(a);
  endfunction

  function automatic logic [31:0] rread(logic [22:0] a);
    return rmem.exists(a) ? rmem[a] : initv(a);
  endfunction

  function automatic logic any_out();
    return |{ack, rdata, mc_read_a, mc_read_b, mc_write, mc_refresh,
             mc_addr, mc_din, mc_mask, timeout_err, refresh_missed};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // SDRAM controller model: busy for 4 cycles after each command
  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      busy_left = 0;
      hang = 1'b0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (mc_read_a || mc_read_b || mc_write || mc_refresh) begin
        busy_left = 4;
        if (mc_write) begin
          cmem[mc_addr] = merge(cread(mc_addr), mc_din, mc_mask);
          if (stuck) hang = 1'b1;
        end
        if (mc_read_a) begin
          mc_dout_a = cread(mc_addr);
          mc_dout_b = $urandom;
        end
        if (mc_read_b) begin
          mc_dout_b = cread(mc_addr);
          mc_dout_a = $urandom;
        end
      end
      if (!stuck) hang = 1'b0;
    end
    #1 mc_busy = hang || busy_left > 0;
  end

  // monitor: command legality and ack/rdata scoreboard
  always @(negedge clk) begin : mon
    int n;
    int g;
    logic [31:0] e;
    if (resetn) begin
      n = int'(mc_read_a) + int'(mc_read_b) + int'(mc_write) + int'(mc_refresh);
      if (n > 0) begin
        chk("cmd_onehot", n, 1);
        chk("cmd_pulse", prev_n, 0);
        last_cmd_cyc = cyc;
        if (mc_refresh) begin
          chk("ref_fields", {mc_addr, mc_din, mc_mask}, '0);
          nref++;
          cmdlog.push_back(2);
        end else begin
          g = int'(mc_addr[22]);
          chk("cmd_req", req[g], 1);
          chk("cmd_kind", {mc_read_a, mc_read_b, mc_write},
              we[g] ? 3'b001 : (g == 0 ? 3'b100 : 3'b010));
          chk("cmd_fields", {mc_addr, mc_mask}, {addr[g], mask[g]});
          if (mc_write) chk("cmd_din", mc_din, wdata[g]);
          cmdlog.push_back(g);
        end
      end
      prev_n = n;
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          if ((p == 0 ? expq0.size() : expq1.size()) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack%0d_unexpected: rdata %h, required no ack", p, rdata[p]);
          end else begin
            if (p == 0) e = expq0.pop_front();
            else e = expq1.pop_front();
            chk($sformatf("rdata%0d", p), rdata[p], e);
            acklog.push_back(p);
            ackcyc.push_back(cyc);
            last_ack_cyc[p] = cyc;
          end
        end
      end
    end else begin
      prev_n = 0;
    end
  end

  task automatic do_req(input int p, input bit w, input logic [21:0] a, input int gap);
    logic [22:0] fa;
    logic [31:0] d;
    logic [31:0] e;
    logic [3:0]  m;
    int t;
    repeat (gap) @(posedge clk);
    #1;
    fa = {p[0], a};
    d = $urandom;
    m = 4'($urandom_range(1, 15));
    if (w) begin
      rmem[fa] = merge(rread(fa), d, m);
      e = last_rd[p];
    end else begin
      e = rread(fa);
      last_rd[p] = e;
    end
    if (p == 0) expq0.push_back(e);
    else expq1.push_back(e);
    req[p] = 1'b1;
    we[p] = w;
    addr[p] = fa;
    wdata[p] = d;
    mask[p] = m;
    req_cyc[p] = cyc;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!ack[p] && t < 300);
    if (!ack[p]) begin
      vectors++;
      miscompares++;
      $display("FAIL ack%0d_wait: no ack in %0d cycles, required ack", p, t);
    end
    #1 req[p] = 1'b0;
  endtask

  task automatic port_seq(input int p, input int n, input int gapmax, input int wpct);
    for (int i = 0; i < n; i++)
      do_req(p, $urandom_range(0, 99) < wpct, 22'($urandom_range(0, 15)),
             $urandom_range(0, gapmax));
  endtask

  initial begin
    #300000;
    miscompares++;
    $display("FAIL watchdog: time %0t, required earlier finish", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int base, r0, lat, gap;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1 chk("rst_outs", any_out(), 0);
    @(negedge clk) resetn = 1'b1;

    repeat (40) @(posedge clk);
    #1 chk("missed_early", refresh_missed, 0);
    repeat (30) @(posedge clk);
    #1 chk("missed_set", refresh_missed, 1);
    chk("no_cmd_uninit", cmdlog.size(), 0);
    mc_initialized = 1'b1;
    r0 = nref;
    lat = 0;
    while (nref == r0 && lat < 10) begin
      @(posedge clk);
      lat++;
    end
    chk("ref_after_init", nref - r0, 1);
    repeat (8) @(posedge clk);

    do_req(0, 1'b0, 22'h100, 0);
    chk("rd_issue_lat", last_cmd_cyc - req_cyc[0], 1);
    chk("rd_ack_lat", last_ack_cyc[0] - req_cyc[0], 7);
    chk("rd_data", rdata[0], 32'hDEADBEEF);
    chk("ref_once", nref - r0, 1);
    chk("missed_sticky", refresh_missed, 1);

    base = acklog.size();
    r0 = nref;
    fork
      port_seq(0, 4, 0, 0);
      port_seq(1, 4, 0, 0);
    join
    chk("cont_count", acklog.size() - base, 8);
    for (int i = base; i < acklog.size(); i++) begin
      chk("cont_order", acklog[i], ((i - base) % 2 == 0) ? 1 : 0);
      if (i > base) begin
        gap = ackcyc[i] - ackcyc[i-1];
        chk("cont_gap", gap == 8 || gap == 15, 1);
      end
    end
    chk("cont_refresh", nref > r0, 1);

    fork
      port_seq(0, 25, 4, 40);
      port_seq(1, 25, 4, 40);
    join
    chk("sb_drain", expq0.size() + expq1.size(), 0);

    chk("to_clear", timeout_err, 0);
    stuck = 1'b1;
    do_req(1, 1'b1, 22'h7, 0);
    lat = last_ack_cyc[1] - req_cyc[1];
    chk("to_err", timeout_err, 1);
    chk("to_lat", lat >= 17 && lat <= 25, 1);
    stuck = 1'b0;
    repeat (2) @(posedge clk);
    do_req(0, 1'b0, 22'h3, 0);
    chk("to_recover", last_ack_cyc[0] - req_cyc[0] <= 14, 1);
    chk("to_sticky", timeout_err, 1);

    @(posedge clk);
    #1;
    req[0] = 1'b1;
    we[0] = 1'b0;
    addr[0] = 23'h5;
    lat = 0;
    while (!mc_read_a && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_grant", mc_read_a, 1);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk("rst_async", any_out(), 0);
    repeat (3) @(posedge clk);
    req[0] = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk) resetn = 1'b1;
    base = cmdlog.size();
    fork
      do_req(0, 1'b0, 22'h9, 0);
      do_req(1, 1'b0, 22'h9, 0);
    join
    chk("rst_cmds", cmdlog.size() - base, 2);
    if (cmdlog.size() > base) chk("rst_first_p1", cmdlog[base], 1);
    chk("rst_missed_clr", refresh_missed, 0);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
